// File: rtl/nucleotide_packer_if.sv
// Handshake bundle for nucleotide_packer: start/length, base stream in, packed word stream out.
// Counter signals exist only when BASE_COUNT_EN is defined.
interface nucleotide_packer_if #(
    parameter int SEQ_LEN_W = 16,
    parameter int BPW       = 16
);
    localparam int NBW = $clog2(BPW + 1);

    logic                 start;
    logic [SEQ_LEN_W-1:0] seq_len;
    logic [1:0]           base_in;
    logic                 base_valid;
    logic                 base_ready;
    logic [2*BPW-1:0]     word_out;
    logic                 word_valid;
    logic                 word_ready;
    logic                 word_last;
    logic [NBW-1:0]       word_nbases;
    logic                 busy;
    logic                 done;
`ifdef BASE_COUNT_EN
    logic [SEQ_LEN_W-1:0] cnt_a;
    logic [SEQ_LEN_W-1:0] cnt_c;
    logic [SEQ_LEN_W-1:0] cnt_g;
    logic [SEQ_LEN_W-1:0] cnt_t;

    modport master (
        output start, seq_len, base_in, base_valid, word_ready,
        input  base_ready, word_out, word_valid, word_last, word_nbases, busy, done,
        input  cnt_a, cnt_c, cnt_g, cnt_t
    );
    modport slave (
        input  start, seq_len, base_in, base_valid, word_ready,
        output base_ready, word_out, word_valid, word_last, word_nbases, busy, done,
        output cnt_a, cnt_c, cnt_g, cnt_t
    );
`else
    modport master (
        output start, seq_len, base_in, base_valid, word_ready,
        input  base_ready, word_out, word_valid, word_last, word_nbases, busy, done
    );
    modport slave (
        input  start, seq_len, base_in, base_valid, word_ready,
        output base_ready, word_out, word_valid, word_last, word_nbases, busy, done
    );
`endif
endinterface

// File: rtl/nucleotide_packer.sv
// Packs a fixed-length stream of 2-bit nucleotide codes LSB-first into 2*BPW-bit words.
// Define BASE_COUNT_EN to add per-base composition counters.
//
// state   | meaning
// IDLE    | waiting for start; seq_len=0 start just pulses done
// FILL    | accepting bases into the pack register
// DRAIN   | all bases taken, waiting for the last word handshake
module nucleotide_packer #(
    parameter int SEQ_LEN_W = 16,
    parameter int BPW       = 16
) (
    input  logic              clk,
    input  logic              reset,
    nucleotide_packer_if.slave bus
);
    localparam int WW   = 2 * BPW;
    localparam int NBW  = $clog2(BPW + 1);
    localparam int IDXW = $clog2(BPW);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DRAIN} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [SEQ_LEN_W-1:0] r_left;
    logic [IDXW-1:0]      r_idx;
    logic [WW-1:0]        r_pack;
    logic [WW-1:0]        r_word;
    logic                 r_word_valid;
    logic                 r_last;
    logic [NBW-1:0]       r_nbases;
    logic                 r_done;

    logic                 w_start_ok;
    logic                 w_start_zero;
    logic                 w_final;
    logic                 w_full;
    logic                 w_completing;
    logic                 w_base_acc;
    logic                 w_word_acc;
    logic                 w_base_ready;
    logic                 w_busy;
    logic [WW-1:0]        w_base_sh;
    logic [NBW-1:0]       w_nbases;

    assign w_start_ok   = (r_state == S_IDLE) && bus.start && (bus.seq_len != '0);
    assign w_start_zero = (r_state == S_IDLE) && bus.start && (bus.seq_len == '0);
    assign w_final      = (r_left == SEQ_LEN_W'(1));
    assign w_full       = (r_idx == IDXW'(BPW - 1));
    assign w_completing = w_final || w_full;
    assign w_base_acc   = bus.base_valid && w_base_ready;
    assign w_word_acc   = r_word_valid && bus.word_ready;
    assign w_base_sh    = {{(WW-2){1'b0}}, bus.base_in} << {r_idx, 1'b0};
    assign w_nbases     = NBW'(r_idx) + NBW'(1);

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok)               w_next = S_FILL;
            S_FILL:  if (w_base_acc && w_final)    w_next = S_DRAIN;
            S_DRAIN: if (w_word_acc && r_last)     w_next = S_IDLE;
            default:                               w_next = S_IDLE;
        endcase
    end

    // A completing base may only land if the output register is empty or emptying this edge.
    always_comb begin
        w_base_ready = 1'b0;
        w_busy       = 1'b0;
        if (r_state == S_FILL)
            w_base_ready = !w_completing || !r_word_valid || bus.word_ready;
        if (r_state != S_IDLE)
            w_busy = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_left       <= '0;
            r_idx        <= '0;
            r_pack       <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_last       <= 1'b0;
            r_nbases     <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_start_zero || ((r_state == S_DRAIN) && w_word_acc && r_last);
            if (w_start_ok) begin
                r_left <= bus.seq_len;
                r_idx  <= '0;
                r_pack <= '0;
            end
            if (w_word_acc)
                r_word_valid <= 1'b0;
            if (w_base_acc) begin
                r_left <= r_left - SEQ_LEN_W'(1);
                if (w_completing) begin
                    r_word       <= r_pack | w_base_sh;
                    r_nbases     <= w_nbases;
                    r_last       <= w_final;
                    r_word_valid <= 1'b1;
                    r_pack       <= '0;
                    r_idx        <= '0;
                end else begin
                    r_pack <= r_pack | w_base_sh;
                    r_idx  <= r_idx + IDXW'(1);
                end
            end
        end
    end

    assign bus.base_ready  = w_base_ready;
    assign bus.busy        = w_busy;
    assign bus.done        = r_done;
    assign bus.word_out    = r_word;
    assign bus.word_valid  = r_word_valid;
    assign bus.word_last   = r_last;
    assign bus.word_nbases = r_nbases;

`ifdef BASE_COUNT_EN
    logic [SEQ_LEN_W-1:0] r_cnt [4];

    always_ff @(posedge clk) begin
        if (reset || ((r_state == S_IDLE) && bus.start)) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else if (w_base_acc) begin
            r_cnt[bus.base_in] <= r_cnt[bus.base_in] + SEQ_LEN_W'(1);
        end
    end

    assign bus.cnt_a = r_cnt[0];
    assign bus.cnt_c = r_cnt[1];
    assign bus.cnt_g = r_cnt[2];
    assign bus.cnt_t = r_cnt[3];
`endif
endmodule
